// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-file port between the I2C controller
// (requester 0) and an on-chip engine (requester 1), with per-requester FIFOs.
package i2c_pkg;
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       write_en;
        logic       read_en;
    } reg_bus_t;
endpackage

module reg_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int REG_COUNT  = 28
) (
    input  logic       clk,
    input  logic       reset_n,
    input  reg_bus_t   req0_bus,
    output logic       req0_busy,
    output logic [7:0] req0_rd_data,
    output logic       req0_rd_valid,
    input  reg_bus_t   req1_bus,
    output logic       req1_busy,
    output logic [7:0] req1_rd_data,
    output logic       req1_rd_valid,
    output reg_bus_t   rf_bus,
    input  logic [7:0] rf_rd_data,
    output logic       drop_err
);

    localparam int            PW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW           = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LP_FULL      = CW'(FIFO_DEPTH);
    localparam logic [7:0]    LP_REG_COUNT = 8'(REG_COUNT);

    reg_bus_t      w_req [2];
    reg_bus_t      r_mem [2][FIFO_DEPTH];
    logic [PW-1:0] r_wptr [2];
    logic [PW-1:0] r_rptr [2];
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    w_ne;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [1:0]    w_drop;
    logic          w_gnt_valid;
    logic          w_gnt_id;
    reg_bus_t      w_head;
    logic          r_last_grant;
    reg_bus_t      r_rf_bus;
    logic [7:0]    r_rd_data [2];
    logic [1:0]    r_rd_valid;
    logic          r_drop_err;

    assign w_req[0] = req0_bus;
    assign w_req[1] = req1_bus;

    // Full is judged on the registered count, so a pop in the same cycle never frees a slot.
    always_comb begin
        w_ne   = '0;
        w_push = '0;
        w_drop = '0;
        for (int i = 0; i < 2; i++) begin
            w_ne[i]   = (r_cnt[i] != '0);
            w_push[i] = (w_req[i].write_en ^ w_req[i].read_en)
                        && (w_req[i].addr < LP_REG_COUNT)
                        && (r_cnt[i] != LP_FULL);
            w_drop[i] = (w_req[i].write_en | w_req[i].read_en) && !w_push[i];
        end
    end

    always_comb begin
        w_gnt_valid = |w_ne;
        w_gnt_id    = 1'b0;
        if (w_ne == 2'b11) begin
            w_gnt_id = ~r_last_grant;
        end else if (w_ne == 2'b10) begin
            w_gnt_id = 1'b1;
        end
        w_pop = '0;
        if (w_gnt_valid) begin
            w_pop[w_gnt_id] = 1'b1;
        end
        w_head = r_mem[w_gnt_id][r_rptr[w_gnt_id]];
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + PW'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PW'(1);
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end else if (!w_push[i] && w_pop[i]) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= w_req[i];
            end
        end
    end

    // r_last_grant changes only when rf_bus is loaded, so it also names the owner of rf_bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_bus     <= '0;
            r_last_grant <= 1'b1;
            r_rd_valid   <= '0;
            r_rd_data[0] <= '0;
            r_rd_data[1] <= '0;
            r_drop_err   <= 1'b0;
        end else begin
            r_drop_err <= |w_drop;
            r_rf_bus   <= w_gnt_valid ? w_head : '0;
            if (w_gnt_valid) begin
                r_last_grant <= w_gnt_id;
            end
            r_rd_valid <= '0;
            if (r_rf_bus.read_en) begin
                r_rd_valid[r_last_grant] <= 1'b1;
                r_rd_data[r_last_grant]  <= rf_rd_data;
            end
        end
    end

    assign rf_bus        = r_rf_bus;
    assign req0_busy     = (r_cnt[0] == LP_FULL);
    assign req1_busy     = (r_cnt[1] == LP_FULL);
    assign req0_rd_data  = r_rd_data[0];
    assign req1_rd_data  = r_rd_data[1];
    assign req0_rd_valid = r_rd_valid[0];
    assign req1_rd_valid = r_rd_valid[1];
    assign drop_err      = r_drop_err;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: per-cycle vector table plus a hand-written
// reset-during-traffic sequence.
module tb_reg_bus_arbiter;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    reg_bus_t   req0_bus = '0;
    reg_bus_t   req1_bus = '0;
    logic       req0_busy, req1_busy, req0_rd_valid, req1_rd_valid, drop_err;
    logic [7:0] req0_rd_data, req1_rd_data, rf_rd_data;
    reg_bus_t   rf_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register-file model: read data is a fixed function of the address.
    assign rf_rd_data = rf_bus.read_en ? (rf_bus.addr ^ 8'h52) : 8'h00;

    reg_bus_arbiter #(.FIFO_DEPTH(2), .REG_COUNT(28)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_bus(req0_bus), .req0_busy(req0_busy),
        .req0_rd_data(req0_rd_data), .req0_rd_valid(req0_rd_valid),
        .req1_bus(req1_bus), .req1_busy(req1_busy),
        .req1_rd_data(req1_rd_data), .req1_rd_valid(req1_rd_valid),
        .rf_bus(rf_bus), .rf_rd_data(rf_rd_data), .drop_err(drop_err)
    );

    typedef struct {
        logic       rst;
        reg_bus_t   r0;
        reg_bus_t   r1;
        reg_bus_t   e_rf;
        logic [4:0] e_flags;  // {drop, busy0, busy1, rdv0, rdv1}
        logic [7:0] e_rdd0;
        logic [7:0] e_rdd1;
    } vec_t;

    vec_t vecs[$];

    function automatic reg_bus_t wr(input logic [7:0] a, input logic [7:0] d);
        reg_bus_t b;
        b = '{addr: a, data: d, write_en: 1'b1, read_en: 1'b0};
        return b;
    endfunction

    function automatic reg_bus_t rd(input logic [7:0] a);
        reg_bus_t b;
        b = '{addr: a, data: 8'h00, write_en: 1'b0, read_en: 1'b1};
        return b;
    endfunction

    localparam reg_bus_t NOP  = '0;
    localparam reg_bus_t BOTH = '{addr: 8'h02, data: 8'h00, write_en: 1'b1, read_en: 1'b1};

    task automatic add(input logic rst, input reg_bus_t r0, input reg_bus_t r1,
                       input reg_bus_t e_rf, input logic [4:0] fl,
                       input logic [7:0] d0, input logic [7:0] d1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.e_rf = e_rf;
        v.e_flags = fl; v.e_rdd0 = d0; v.e_rdd1 = d1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        req0_bus = '0;
        req1_bus = '0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drive(input reg_bus_t r0, input reg_bus_t r1);
        @(negedge clk);
        req0_bus = r0;
        req1_bus = r1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single write
        add(1, wr(8'h01, 8'hAA), NOP, NOP,              5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP,              wr(8'h01, 8'hAA), 5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP,              NOP,              5'b00000, 8'h00, 8'h00);
        // Round-robin tie from reset
        add(1, wr(8'h02, 8'h11), wr(8'h03, 8'h22), NOP,  5'b00000, 8'h00, 8'h00);
        add(0, wr(8'h04, 8'h33), wr(8'h05, 8'h44), wr(8'h02, 8'h11), 5'b00100, 8'h00, 8'h00);
        add(0, NOP, NOP, wr(8'h03, 8'h22), 5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP, wr(8'h04, 8'h33), 5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP, wr(8'h05, 8'h44), 5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP, NOP,              5'b00000, 8'h00, 8'h00);
        // Overflow: both write every cycle for 8 cycles, then drain
        add(1, wr(8'h11, 8'hA1), wr(8'h09, 8'hB1), NOP,              5'b00000, 8'h00, 8'h00);
        add(0, wr(8'h12, 8'hA2), wr(8'h0A, 8'hB2), wr(8'h11, 8'hA1), 5'b00100, 8'h00, 8'h00);
        add(0, wr(8'h13, 8'hA3), wr(8'h0B, 8'hB3), wr(8'h09, 8'hB1), 5'b11000, 8'h00, 8'h00);
        add(0, wr(8'h14, 8'hA4), wr(8'h0C, 8'hB4), wr(8'h12, 8'hA2), 5'b10100, 8'h00, 8'h00);
        add(0, wr(8'h15, 8'hA5), wr(8'h0D, 8'hB5), wr(8'h0A, 8'hB2), 5'b11000, 8'h00, 8'h00);
        add(0, wr(8'h16, 8'hA6), wr(8'h0E, 8'hB6), wr(8'h13, 8'hA3), 5'b10100, 8'h00, 8'h00);
        add(0, wr(8'h17, 8'hA7), wr(8'h0F, 8'hB7), wr(8'h0C, 8'hB4), 5'b11000, 8'h00, 8'h00);
        add(0, wr(8'h18, 8'hA8), wr(8'h10, 8'hB8), wr(8'h15, 8'hA5), 5'b10100, 8'h00, 8'h00);
        add(0, NOP, NOP, wr(8'h0E, 8'hB6), 5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP, wr(8'h17, 8'hA7), 5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP, wr(8'h10, 8'hB8), 5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP, NOP,              5'b00000, 8'h00, 8'h00);
        // Read routing (model returns addr ^ 0x52)
        add(0, NOP, rd(8'h07), NOP,       5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP,       rd(8'h07), 5'b00000, 8'h00, 8'h00);
        add(0, NOP, NOP,       NOP,       5'b00001, 8'h00, 8'h55);
        add(0, NOP, NOP,       NOP,       5'b00000, 8'h00, 8'h55);
        add(0, rd(8'h0A), NOP, NOP,       5'b00000, 8'h00, 8'h55);
        add(0, NOP, NOP,       rd(8'h0A), 5'b00000, 8'h00, 8'h55);
        add(0, NOP, NOP,       NOP,       5'b00010, 8'h58, 8'h55);
        add(0, NOP, NOP,       NOP,       5'b00000, 8'h58, 8'h55);
        // Illegal requests and address boundary
        add(0, wr(8'h30, 8'h77), NOP,  NOP,              5'b10000, 8'h58, 8'h55);
        add(0, NOP, BOTH,              NOP,              5'b10000, 8'h58, 8'h55);
        add(0, wr(8'h1B, 8'h5A), wr(8'h1C, 8'h66), NOP,  5'b10000, 8'h58, 8'h55);
        add(0, wr(8'h3F, 8'h00), wr(8'hFF, 8'h00), wr(8'h1B, 8'h5A), 5'b10000, 8'h58, 8'h55);
        add(0, NOP, NOP,               NOP,              5'b00000, 8'h58, 8'h55);

        apply_reset();
        chk("reset rf_bus", 32'(rf_bus), 32'h0);
        chk("reset flags", {27'd0, drop_err, req0_busy, req1_busy, req0_rd_valid, req1_rd_valid}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) apply_reset();
            drive(vecs[i].r0, vecs[i].r1);
            chk($sformatf("row%0d rf_bus", i), 32'(rf_bus), 32'(vecs[i].e_rf));
            chk($sformatf("row%0d drop_err", i), 32'(drop_err), 32'(vecs[i].e_flags[4]));
            chk($sformatf("row%0d req0_busy", i), 32'(req0_busy), 32'(vecs[i].e_flags[3]));
            chk($sformatf("row%0d req1_busy", i), 32'(req1_busy), 32'(vecs[i].e_flags[2]));
            chk($sformatf("row%0d req0_rd_valid", i), 32'(req0_rd_valid), 32'(vecs[i].e_flags[1]));
            chk($sformatf("row%0d req1_rd_valid", i), 32'(req1_rd_valid), 32'(vecs[i].e_flags[0]));
            chk($sformatf("row%0d req0_rd_data", i), 32'(req0_rd_data), 32'(vecs[i].e_rdd0));
            chk($sformatf("row%0d req1_rd_data", i), 32'(req1_rd_data), 32'(vecs[i].e_rdd1));
        end

        // Reset with both FIFOs occupied and a read on rf_bus
        drive(rd(8'h03), NOP);
        drive(wr(8'h05, 8'hC5), wr(8'h06, 8'hC6));
        chk("pre-reset read in flight", 32'(rf_bus), 32'(rd(8'h03)));
        req0_bus = '0;
        req1_bus = '0;
        reset_n  = 1'b0;
        #1;
        chk("async rf_bus", 32'(rf_bus), 32'h0);
        chk("async rd_data", {16'd0, req0_rd_data, req1_rd_data}, 32'h0);
        chk("async flags", {27'd0, drop_err, req0_busy, req1_busy, req0_rd_valid, req1_rd_valid}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(NOP, NOP);
            chk($sformatf("post-reset%0d rf_bus", k), 32'(rf_bus), 32'h0);
            chk($sformatf("post-reset%0d rd_valid", k), {30'd0, req0_rd_valid, req1_rd_valid}, 32'h0);
        end
        drive(wr(8'h1A, 8'hE0), wr(8'h19, 8'hE1));
        chk("post-reset tie idle", 32'(rf_bus), 32'h0);
        drive(NOP, NOP);
        chk("post-reset tie first", 32'(rf_bus), 32'(wr(8'h1A, 8'hE0)));
        drive(NOP, NOP);
        chk("post-reset tie second", 32'(rf_bus), 32'(wr(8'h19, 8'hE1)));
        drive(NOP, NOP);
        chk("post-reset tie done", 32'(rf_bus), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Two-requester arbiter that shares the LED driver's single register-file port between `i2c_controller` (requester 0) and a local on-chip engine (requester 1, e.g. blink/auto-sequence logic). Each requester drives a `reg_bus_t` (from `i2c_pkg`) and may issue one request per cycle without stalling. Requests are buffered per requester, arbitrated round-robin, and issued one per cycle on a registered `reg_bus_t` to the register file. Read data is routed back to the originating requester.

## Interface
- `FIFO_DEPTH`, 2, entries per requester FIFO; power of two, ≥2
- `REG_COUNT`, 28, number of implemented registers; legal addresses are 0 .. `REG_COUNT`-1
- `clk`  in  1  system clock; single clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `req0_bus`  in  reg_bus_t  requester 0 (I2C controller); `write_en`/`read_en` are 1-cycle request strobes
- `req0_busy`  out  1  requester 0 FIFO full
- `req0_rd_data`  out  8  read return data for requester 0
- `req0_rd_valid`  out  1  1-cycle strobe qualifying `req0_rd_data`
- `req1_bus`, `req1_busy`, `req1_rd_data`, `req1_rd_valid`: same as requester 0, for requester 1
- `rf_bus`  out  reg_bus_t  registered request to the register file
- `rf_rd_data`  in  8  register-file read data; combinational from `rf_bus.addr` while `rf_bus.read_en`=1
- `drop_err`  out  1  1-cycle strobe: at least one request dropped this cycle

## Operation
- Request capture, per requester, at each rising edge:
  - `write_en`=1, `read_en`=0: write request (addr, data).
  - `read_en`=1, `write_en`=0: read request (addr).
  - Both strobes high, `addr` ≥ `REG_COUNT`, or FIFO full: request dropped, `drop_err`=1 the next cycle.
  - Otherwise pushed to that requester's FIFO.
- Full is judged on the registered count before the edge. A push while full is dropped even if a pop occurs in the same cycle.
- Arbitration each cycle:
  - If exactly one FIFO is non-empty, grant it.
  - If both are non-empty, grant the requester not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - The granted head is popped. `rf_bus` is loaded at the next edge with addr, data, `write_en`/`read_en` of that entry.
  - With no grant, `rf_bus` loads all zeros. Strobes are never high for more than one cycle per request.
- Ordering: strictly in order within a requester; no ordering guarantee between requesters.
- Read return:
  - When `rf_bus.read_en`=1, `rf_rd_data` and the grant owner are captured at the next edge.
  - The matching `reqN_rd_data` updates and `reqN_rd_valid` pulses for one cycle. The other requester's `rd_valid` stays 0.
  - `reqN_rd_data` holds its value until the next read return for that requester.
- `drop_err` ORs both requesters; drops from both in the same cycle give a single pulse.

## Timing
- Reset (async assert, sync-safe release):
  - `rf_bus`=0; all `rd_data`, `rd_valid`, `busy`, `drop_err` = 0.
  - FIFOs empty; `last_grant`=1.
  - Any in-flight read return is cancelled.
- Request sampled at edge k into an empty FIFO with no competition: on `rf_bus` during cycle k+1 (after edge k+1). One-cycle latency.
- Read sampled at edge k: `rf_bus.read_en` after edge k+1; `reqN_rd_valid` after edge k+2.
- Throughput: one register access per cycle total. Under sustained contention each requester gets every other slot.
- `reqN_busy` = (count == `FIFO_DEPTH`), derived from registered count only. Drops from overflow are therefore possible only when input rate exceeds granted rate.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.

## Test plan
- **Single write:** after reset, `req0_bus` write addr 0x01 data 0xAA for 1 cycle -> one cycle later `rf_bus` = {we=1, addr 0x01, data 0xAA} for exactly 1 cycle; `drop_err` stays 0.
- **Round-robin tie:** both requesters write in the same cycle (req0: 0x02/0x11, req1: 0x03/0x22), repeated next cycle (0x04/0x33, 0x05/0x44) -> `rf_bus` order 0x02, 0x03, 0x04, 0x05 on consecutive cycles.
- **Read routing:** `req1_bus` read addr 0x07 while the model returns 0x55 -> `req1_rd_valid`=1 with `req1_rd_data`=0x55 two cycles after the request; `req0_rd_valid` stays 0.
- **Overflow:** `FIFO_DEPTH`=2; both requesters write every cycle for 8 cycles -> `req0_busy`/`req1_busy` assert; `drop_err` pulses on each dropped request; every `rf_bus` write matches an accepted request, in per-requester order, alternating owners.
- **Illegal request:** write to addr 0x30 (`REG_COUNT`=28), or both strobes high -> `drop_err` pulse one cycle later; no `rf_bus` activity.
- **Reset mid-operation:** assert `reset_n`=0 with both FIFOs holding entries and a read in flight -> all outputs 0 immediately. After release, no stale `rf_bus` activity or `rd_valid` appears, and the next tie is granted to requester 0.
